// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array sequencer: FSM states and the CSR map.
// The CSR constants are also consumed by the Nios driver header generator.
package systolic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_FLUSH,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_K_LEN  = 2'd2;
    localparam logic [1:0] ADDR_CYCLES = 2'd3;

    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_ABORT  = 2;

    localparam int STATUS_BUSY = 0;
    localparam int STATUS_DONE = 1;
    localparam int STATUS_ERR  = 2;

endpackage

// File: rtl/systolic_csr.sv
// Avalon-MM CSR slave for the sequencer: register file, start/abort decode and irq.
module systolic_csr
    import systolic_pkg::*;
#(
    parameter int KW = 8,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [1:0]    avs_address,
    input  logic          avs_write,
    input  logic [31:0]   avs_writedata,
    input  logic          avs_read,
    output logic [31:0]   avs_readdata,
    output logic          irq,
    input  logic          busy,
    input  logic          run_done,
    input  logic [CW-1:0] run_cycles,
    output logic          start_req,
    output logic          abort_req,
    output logic [KW-1:0] k_len
);

    logic          irq_en;
    logic          done;
    logic          err;
    logic [CW-1:0] cycles;
    logic [31:0]   rd_mux;

    logic ctrl_wr, status_wr, k_wr;
    logic start_hit, err_set, done_set;

    assign ctrl_wr   = avs_write && (avs_address == ADDR_CTRL);
    assign status_wr = avs_write && (avs_address == ADDR_STATUS);
    assign k_wr      = avs_write && (avs_address == ADDR_K_LEN);

    // Abort written together with start suppresses the start.
    assign start_hit = ctrl_wr && avs_writedata[CTRL_START] && !avs_writedata[CTRL_ABORT];
    assign start_req = start_hit && !busy && (k_len != '0);
    assign err_set   = start_hit && !busy && (k_len == '0);
    assign abort_req = ctrl_wr && avs_writedata[CTRL_ABORT] && busy;
    assign done_set  = run_done && !abort_req;

    assign irq = done && irq_en;

    always_comb begin
        // NOTE: default first so every path assigns rd_mux and no latch is inferred.
        rd_mux = '0;
        case (avs_address)
            ADDR_CTRL:   rd_mux[CTRL_IRQ_EN] = irq_en;
            ADDR_STATUS: begin
                rd_mux[STATUS_BUSY] = busy;
                rd_mux[STATUS_DONE] = done;
                rd_mux[STATUS_ERR]  = err;
            end
            ADDR_K_LEN:  rd_mux = 32'(k_len);
            default:     rd_mux = 32'(cycles);
        endcase
    end

    // NOTE: state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en       <= 1'b0;
            k_len        <= '0;
            cycles       <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
            avs_readdata <= '0;
        end else begin
            if (ctrl_wr) irq_en <= avs_writedata[CTRL_IRQ_EN];
            if (k_wr) k_len <= avs_writedata[KW-1:0];
            if (done_set) cycles <= run_cycles;
            // Set beats a same-cycle write-1-to-clear.
            done <= done_set || (done && !(status_wr && avs_writedata[STATUS_DONE]));
            err  <= err_set  || (err  && !(status_wr && avs_writedata[STATUS_ERR]));
            if (avs_read) avs_readdata <= rd_mux;
        end
    end

endmodule

// File: rtl/systolic_array_sequencer.sv
// Sequencer for one output-stationary NxN systolic array run: clear, skewed feed,
// flush, row drain, done. All array-facing outputs are registered.
module systolic_array_sequencer
    import systolic_pkg::*;
#(
    parameter int N  = 4,
    parameter int KW = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [1:0]           avs_address,
    input  logic                 avs_write,
    input  logic [31:0]          avs_writedata,
    input  logic                 avs_read,
    output logic [31:0]          avs_readdata,
    output logic                 irq,
    output logic                 arr_clear,
    output logic [N-1:0]         feed_valid,
    output logic [N*KW-1:0]      feed_idx,
    output logic                 drain_en,
    output logic [$clog2(N)-1:0] drain_row
);

    localparam int RW = $clog2(N);
    localparam int TW = KW + RW + 1;   // feed counter, wide enough that t < i+K never wraps
    localparam int CW = KW + RW + 2;   // holds K+3N

    state_t        state;
    logic [TW-1:0] cnt;
    logic [KW-1:0] k_run;
    logic [CW-1:0] cycles;
    logic [KW-1:0] k_len;
    logic          start_req;
    logic          abort_req;
    logic          busy;

    assign busy = (state != ST_IDLE);

    systolic_csr #(.KW(KW), .CW(CW)) u_csr (
        .clk           (clk),
        .reset_n       (reset_n),
        .avs_address   (avs_address),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_read      (avs_read),
        .avs_readdata  (avs_readdata),
        .irq           (irq),
        .busy          (busy),
        .run_done      (state == ST_DONE),
        .run_cycles    (cycles),
        .start_req     (start_req),
        .abort_req     (abort_req),
        .k_len         (k_len)
    );

    // Row/column i sees index t-i while t lies in [i, i+K).
    function automatic logic [N+N*KW-1:0] skew(input logic [TW-1:0] t, input logic [KW-1:0] k);
        logic [N-1:0]    v;
        logic [N*KW-1:0] x;
        v = '0;
        x = '0;
        for (int i = 0; i < N; i++) begin
            if (t >= TW'(i) && t < TW'(i) + TW'(k)) begin
                v[i]           = 1'b1;
                x[i*KW +: KW]  = KW'(t - TW'(i));
            end
        end
        return {v, x};
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            k_run      <= '0;
            cycles     <= '0;
            arr_clear  <= 1'b0;
            feed_valid <= '0;
            feed_idx   <= '0;
            drain_en   <= 1'b0;
            drain_row  <= '0;
        end else if (abort_req) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            arr_clear  <= 1'b0;
            feed_valid <= '0;
            feed_idx   <= '0;
            drain_en   <= 1'b0;
            drain_row  <= '0;
        end else begin
            if (busy) cycles <= cycles + CW'(1);
            case (state)
                ST_IDLE: begin
                    if (start_req) begin
                        state     <= ST_CLEAR;
                        k_run     <= k_len;
                        cycles    <= CW'(1);
                        arr_clear <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    state                  <= ST_FEED;
                    cnt                    <= '0;
                    arr_clear              <= 1'b0;
                    {feed_valid, feed_idx} <= skew('0, k_run);
                end
                ST_FEED: begin
                    if (cnt == TW'(k_run) + TW'(N - 2)) begin
                        state      <= ST_FLUSH;
                        cnt        <= '0;
                        feed_valid <= '0;
                        feed_idx   <= '0;
                    end else begin
                        cnt                    <= cnt + TW'(1);
                        {feed_valid, feed_idx} <= skew(cnt + TW'(1), k_run);
                    end
                end
                ST_FLUSH: begin
                    if (cnt == TW'(N - 2)) begin
                        state     <= ST_DRAIN;
                        cnt       <= '0;
                        drain_en  <= 1'b1;
                        drain_row <= '0;
                    end else begin
                        cnt <= cnt + TW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (cnt == TW'(N - 1)) begin
                        state     <= ST_DONE;
                        cnt       <= '0;
                        drain_en  <= 1'b0;
                        drain_row <= '0;
                    end else begin
                        cnt       <= cnt + TW'(1);
                        drain_row <= RW'(cnt + TW'(1));
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_array_sequencer.sv
// Self-checking bench: randomized runs compared cycle by cycle against a timeline model.
module tb_systolic_array_sequencer;
    import systolic_pkg::*;

    localparam int N  = 4;
    localparam int KW = 8;
    localparam int RW = 2;
    localparam int BW = 1 + N + N*KW + 1 + RW;

    localparam int INJ_NONE  = 0;
    localparam int INJ_START = 1;
    localparam int INJ_ABORT = 2;
    localparam int INJ_W1C   = 3;
    localparam int INJ_RESET = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [1:0]    avs_address = '0;
    logic          avs_write = 1'b0;
    logic [31:0]   avs_writedata = '0;
    logic          avs_read = 1'b0;
    logic [31:0]   avs_readdata;
    logic          irq;
    logic          arr_clear;
    logic [N-1:0]  feed_valid;
    logic [N*KW-1:0] feed_idx;
    logic          drain_en;
    logic [RW-1:0] drain_row;
    logic [BW-1:0] obs;

    int n_checks = 0;
    int n_fail   = 0;
    int prev_cycles = 0;

    always #5 clk = ~clk;

    systolic_array_sequencer #(.N(N), .KW(KW)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .avs_address   (avs_address),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_read      (avs_read),
        .avs_readdata  (avs_readdata),
        .irq           (irq),
        .arr_clear     (arr_clear),
        .feed_valid    (feed_valid),
        .feed_idx      (feed_idx),
        .drain_en      (drain_en),
        .drain_row     (drain_row)
    );

    assign obs = {arr_clear, feed_valid, feed_idx, drain_en, drain_row};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [1:0] addr, input logic [31:0] data);
        avs_address   = addr;
        avs_writedata = data;
        avs_write     = 1'b1;
        tick();
        avs_write     = 1'b0;
    endtask

    task automatic csr_read(input logic [1:0] addr, output logic [31:0] data);
        avs_address = addr;
        avs_read    = 1'b1;
        tick();
        avs_read    = 1'b0;
        data        = avs_readdata;
    endtask

    // Expected array outputs d cycles after the start write (d=1 is the clear cycle).
    function automatic logic [BW-1:0] model(input int d, input int k);
        logic            clr;
        logic [N-1:0]    fv;
        logic [N*KW-1:0] fi;
        logic            de;
        logic [RW-1:0]   dr;
        clr = (d == 1);
        fv  = '0;
        fi  = '0;
        de  = 1'b0;
        dr  = '0;
        if (d >= 2 && d <= k + N) begin
            int t;
            t = d - 2;
            for (int i = 0; i < N; i++) begin
                if (t >= i && t < i + k) begin
                    fv[i]          = 1'b1;
                    fi[i*KW +: KW] = KW'(t - i);
                end
            end
        end
        if (d >= k + 2*N && d <= k + 3*N - 1) begin
            de = 1'b1;
            dr = RW'(d - k - 2*N);
        end
        return {clr, fv, fi, de, dr};
    endfunction

    task automatic run(input int k, input bit ien, input int inj_kind, input int inj_d);
        int last;
        int row3_last;
        last      = k + 3*N;
        row3_last = -1;
        csr_write(ADDR_K_LEN, 32'(k));
        csr_write(ADDR_CTRL, 32'(1) | (32'(ien) << 1));
        for (int d = 1; d <= last; d++) begin
            check($sformatf("out k=%0d d=%0d", k, d), 64'(obs), 64'(model(d, k)));
            if (feed_valid[3]) row3_last = int'(feed_idx[3*KW +: KW]);
            if (d == inj_d && inj_kind == INJ_RESET) begin
                reset_n = 1'b0;
                #1;
                check("reset_outputs", 64'({irq, obs}), 64'(0));
                return;
            end
            if (d == inj_d && inj_kind != INJ_NONE) begin
                avs_write = 1'b1;
                case (inj_kind)
                    INJ_START: begin avs_address = ADDR_CTRL;   avs_writedata = 32'(1) | (32'(ien) << 1); end
                    INJ_ABORT: begin avs_address = ADDR_CTRL;   avs_writedata = 32'(4) | (32'(ien) << 1); end
                    default:   begin avs_address = ADDR_STATUS; avs_writedata = 32'(2); end
                endcase
            end
            tick();
            avs_write = 1'b0;
            if (d == inj_d && inj_kind == INJ_ABORT) begin
                check("abort_outputs", 64'(obs), 64'(0));
                return;
            end
        end
        check("irq_after_run", 64'(irq), 64'(ien));
        check("row3_last_idx", 64'(row3_last), 64'(k - 1));
    endtask

    initial begin
        logic [31:0] v;
        int k;
        bit ien;

        // Reset state
        #1;
        check("rst_outputs", 64'({irq, obs}), 64'(0));
        check("rst_readdata", 64'(avs_readdata), 64'(0));
        tick();
        reset_n = 1'b1;
        tick();
        for (int a = 0; a < 4; a++) begin
            csr_read(2'(a), v);
            check($sformatf("rst_csr%0d", a), 64'(v), 64'(0));
        end

        // Directed N=4, K=4 run with irq enabled
        run(4, 1'b1, INJ_NONE, 0);
        csr_read(ADDR_CYCLES, v);  check("cycles_k4", 64'(v), 64'(16));
        csr_read(ADDR_STATUS, v);  check("status_k4", 64'(v), 64'(2));
        csr_read(ADDR_CTRL, v);    check("ctrl_rd", 64'(v), 64'(2));
        csr_write(ADDR_STATUS, 32'(2));
        check("irq_cleared", 64'(irq), 64'(0));
        csr_read(ADDR_STATUS, v);  check("status_w1c", 64'(v), 64'(0));
        prev_cycles = 16;

        // Start with K=0 is rejected
        csr_write(ADDR_K_LEN, 32'(0));
        csr_write(ADDR_CTRL, 32'(1));
        check("k0_idle_out", 64'(obs), 64'(0));
        csr_read(ADDR_STATUS, v);  check("k0_err", 64'(v), 64'(4));
        csr_write(ADDR_STATUS, 32'(4));
        csr_read(ADDR_STATUS, v);  check("err_w1c", 64'(v), 64'(0));

        // Abort in the third feed cycle
        run(6, 1'b1, INJ_ABORT, 4);
        csr_read(ADDR_STATUS, v);  check("abort_status", 64'(v), 64'(0));
        check("abort_irq", 64'(irq), 64'(0));
        csr_read(ADDR_CYCLES, v);  check("abort_cycles", 64'(v), 64'(prev_cycles));

        // Start while busy in drain is ignored
        run(5, 1'b0, INJ_START, 5 + 2*N + 1);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("no_rerun%0d", i), 64'(obs), 64'(0));
            tick();
        end
        csr_read(ADDR_STATUS, v);  check("rerun_status", 64'(v), 64'(2));
        csr_read(ADDR_CYCLES, v);  check("rerun_cycles", 64'(v), 64'(5 + 3*N));
        csr_write(ADDR_STATUS, 32'(2));

        // Randomized runs; one has a done W1C landing on the done cycle
        for (int r = 0; r < 6; r++) begin
            k   = int'($urandom_range(1, 20));
            ien = 1'($urandom_range(0, 1));
            run(k, ien, (r == 2) ? INJ_W1C : INJ_NONE, k + 3*N);
            csr_read(ADDR_CYCLES, v);  check($sformatf("rnd_cycles%0d", r), 64'(v), 64'(k + 3*N));
            csr_read(ADDR_STATUS, v);  check($sformatf("rnd_status%0d", r), 64'(v), 64'(2));
            csr_read(ADDR_K_LEN, v);   check($sformatf("rnd_klen%0d", r), 64'(v), 64'(k));
            csr_write(ADDR_STATUS, 32'(2));
        end

        // Maximum K: no index wrap
        run(255, 1'b0, INJ_NONE, 0);
        csr_read(ADDR_CYCLES, v);  check("cycles_k255", 64'(v), 64'(267));
        csr_write(ADDR_STATUS, 32'(2));

        // Reset dropped in the first flush cycle
        run(3, 1'b1, INJ_RESET, 3 + N + 1);
        tick();
        reset_n = 1'b1;
        tick();
        for (int a = 0; a < 4; a++) begin
            csr_read(2'(a), v);
            check($sformatf("midrst_csr%0d", a), 64'(v), 64'(0));
        end
        run(1, 1'b1, INJ_NONE, 0);
        csr_read(ADDR_CYCLES, v);  check("cycles_k1", 64'(v), 64'(13));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_array_sequencer.md
# systolic_array_sequencer

Control block that sequences one run of the output-stationary N×N systolic array: it clears the accumulators, issues skewed operand-fetch strobes for rows and columns, waits for the wavefront to flush, drains the result rows and raises a level interrupt. It sits between the Nios Avalon-MM data master, which programs it through a small CSR slave, and the array plus its operand and result buffers, which it drives directly.

## Interface
- N, 4, array dimension (rows = columns); 2..16
- KW, 8, width of inner-dimension length and fetch indices; K max = 2^KW − 1
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- avs_address  in  2  CSR word address
- avs_write  in  1  CSR write strobe
- avs_writedata  in  32  CSR write data
- avs_read  in  1  CSR read strobe
- avs_readdata  out  32  CSR read data, registered, fixed latency 1
- irq  out  1  level interrupt = done & irq_en
- arr_clear  out  1  clears all PE accumulators
- feed_valid  out  N  bit i: row i and column i operands valid this cycle
- feed_idx  out  N*KW  packed; slice i is the inner-dimension index for row/column i
- drain_en  out  1  array shifts one result row out this cycle
- drain_row  out  clog2(N)  result row being written to the result buffer

## Operation
- CSRs:
  - 0 CTRL: bit0 start (write-1 pulse, reads 0); bit1 irq_en (R/W); bit2 abort (write-1 pulse).
  - 1 STATUS: bit0 busy (RO); bit1 done (sticky, W1C); bit2 err (sticky, W1C).
  - 2 K_LEN: bits[KW-1:0] inner dimension K, R/W.
  - 3 CYCLES: RO cycle count of the last completed run.
- FSM states: IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE.
  - IDLE → CLEAR on an accepted start.
  - CLEAR lasts 1 cycle, with arr_clear=1.
  - FEED lasts K+N−1 cycles, with feed counter t = 0..K+N−2.
  - FLUSH lasts N−1 cycles; all outputs are low.
  - DRAIN lasts N cycles, with drain_en=1 and drain_row = 0..N−1.
  - DONE lasts 1 cycle: sets done, latches CYCLES, then returns to IDLE.
- Skew rule in FEED:
  - feed_valid[i] = (t ≥ i) && (t < i+K).
  - feed_idx slice i = t − i when valid, else 0.
  - Compare in KW+clog2(N)+1 bits; no wrap-around is permitted.
- busy = 1 in every state except IDLE.
- Start handling:
  - A start with K_LEN = 0 is rejected: err is set and the FSM stays in IDLE.
  - A start while busy is ignored; no flag is set.
  - K_LEN is latched at CLEAR. Writes to K_LEN during a run affect only the next run.
- Abort while busy: next cycle the FSM is in IDLE with all array outputs low. done is not set and CYCLES is unchanged.
- If start and abort are written in the same cycle, abort wins.
- CYCLES counts from CLEAR through DONE inclusive: K+3N.
- A W1C of done in the same cycle as DONE leaves done = 1 (set wins).

## Timing
- Reset values:
  - FSM = IDLE; irq_en = 0; K_LEN = 0; CYCLES = 0.
  - done, err, busy = 0.
  - All array outputs = 0; avs_readdata = 0; irq = 0.
- Reset asserted mid-run returns to the reset state asynchronously. No drain completes.
- Start written in cycle c:
  - CLEAR in c+1; first FEED cycle in c+2.
  - Last DRAIN cycle in c+K+3N−1; DONE in c+K+3N.
  - done and irq are visible from cycle c+K+3N+1.
- Reads return data in the cycle after avs_read. There is no waitrequest.
- All array outputs are registered and change only on the rising edge of clk.

## Structure
- Shared package `systolic_pkg` holds:
  - the FSM state enum;
  - CSR address constants;
  - CTRL/STATUS bit-position constants.
  The same constants are used by the Nios driver header generator.
- Natural sub-module: `systolic_csr`, containing the Avalon slave, the register file and the irq logic. The FSM and skew generation live in the top module.

## Test plan
- N=4, K=4, start with irq_en=1:
  - feed_valid sequence 0001, 0011, 0111, 1111, 1110, 1100, 1000.
  - Row-3 indices 0..3 appear in FEED cycles 3..6.
  - drain_row runs 0..3; irq rises; CYCLES reads 16.
- K_LEN=0, then start: FSM stays IDLE, err reads 1. Writing 1 to STATUS bit2 clears err.
- Abort in the 3rd FEED cycle:
  - Next cycle busy=0 and feed_valid=0.
  - done=0; CYCLES keeps its previous value.
- Start again while busy (mid-DRAIN): the run completes unchanged and exactly one DONE occurs.
- Drop reset_n during FLUSH: all outputs are 0 immediately and CSRs hold reset values. After release, a start with K=1 completes in 13 cycles.
- K=255 (KW=8), N=4: no index wraps, the last index issued on row 3 is 254, and CYCLES = 267.
